// File: rtl/wb_cp0_stage_if.sv
// rtl/wb_cp0_stage_if.sv - MEM-to-WB retire bundle for wb_cp0_stage
// Ports (master = MEM side, slave = WB side):
//   ms_to_ws_valid / ws_allowin : retire handshake
//   ms_pc, ms_result, ms_dest, ms_gr_strb : instruction payload and GPR write info
//   ms_ex, ms_excode, ms_badvaddr, ms_bd : upstream exception info
//   ms_inst_eret/mfc0/mtc0, ms_cp0_addr : CP0 instruction class and {rd,sel}
interface wb_cp0_stage_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [31:0] ms_result;
  logic [4:0]  ms_dest;
  logic [3:0]  ms_gr_strb;
  logic        ms_ex;
  logic [4:0]  ms_excode;
  logic [31:0] ms_badvaddr;
  logic        ms_bd;
  logic        ms_inst_eret;
  logic        ms_inst_mfc0;
  logic        ms_inst_mtc0;
  logic [7:0]  ms_cp0_addr;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_result, ms_dest, ms_gr_strb,
           ms_ex, ms_excode, ms_badvaddr, ms_bd,
           ms_inst_eret, ms_inst_mfc0, ms_inst_mtc0, ms_cp0_addr,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_result, ms_dest, ms_gr_strb,
           ms_ex, ms_excode, ms_badvaddr, ms_bd,
           ms_inst_eret, ms_inst_mfc0, ms_inst_mtc0, ms_cp0_addr,
    output ws_allowin
  );
endinterface

// File: rtl/wb_cp0_stage.sv
// rtl/wb_cp0_stage.sv - MIPS writeback stage with embedded CP0, timer and interrupts
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   ms              : MEM-to-WB retire bundle (slave side)
//   ext_int         : level-sensitive external interrupt lines
//   rf_we/waddr/wdata : GPR write port
//   ws_dest_o, ws_inst_mfc0_o : hazard information for earlier stages
//   ws_flush, ws_flush_pc : registered one-cycle flush pulse and its target
//   debug_wb_*      : retire trace
module wb_cp0_stage #(
  parameter int          EXT_INT_W = 6,
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] EX_ENTRY  = 32'hBFC00380
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_cp0_stage_if.slave        ms,
  input  logic [EXT_INT_W-1:0] ext_int,
  output logic [3:0]           rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [4:0]           ws_dest_o,
  output logic                 ws_inst_mfc0_o,
  output logic                 ws_flush,
  output logic [31:0]          ws_flush_pc,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic [3:0]  strb;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic        eret;
    logic        mfc0;
    logic        mtc0;
    logic [7:0]  cp0_addr;
  } payload_t;

  logic        ws_valid_q, ws_valid_d;
  payload_t    pl_q, pl_d;
  logic [5:0]  ext_q, ext_d;
  logic [31:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  logic [5:0]  ip_hw;
  logic [31:0] status_rd, cause_rd, cp0_rdata;
  logic        int_req, take_ex, eret_fire, mtc0_fire;
  logic [4:0]  ex_code;

  // Top hardware IP bit is shared between ext_int[5] and the timer; with
  // fewer lines ext_q[5] is constant zero so IP[15] reduces to TI.
  assign ip_hw     = {ext_q[5] | ti_q, ext_q[4:0]};
  assign status_rd = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti_q, 14'd0, ip_hw, ip_sw_q, 1'b0, exccode_q, 2'b00};

  assign int_req   = ie_q & ~exl_q & (|({ip_hw, ip_sw_q} & im_q));
  assign take_ex   = ws_valid_q & (pl_q.ex | int_req);
  assign ex_code   = pl_q.ex ? pl_q.excode : 5'd0;
  assign eret_fire = ws_valid_q & pl_q.eret & ~take_ex;
  assign mtc0_fire = ws_valid_q & pl_q.mtc0 & ~take_ex;

  always_comb begin
    cp0_rdata = 32'd0;
    case (pl_q.cp0_addr)
      A_BADVADDR: cp0_rdata = badvaddr_q;
      A_COUNT:    cp0_rdata = count_q;
      A_COMPARE:  cp0_rdata = compare_q;
      A_STATUS:   cp0_rdata = status_rd;
      A_CAUSE:    cp0_rdata = cause_rd;
      A_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  always_comb begin
    ws_valid_d = ms.ms_to_ws_valid;
    pl_d       = pl_q;
    if (ms.ms_to_ws_valid) begin
      pl_d.pc       = ms.ms_pc;
      pl_d.result   = ms.ms_result;
      pl_d.dest     = ms.ms_dest;
      pl_d.strb     = ms.ms_gr_strb;
      pl_d.ex       = ms.ms_ex;
      pl_d.excode   = ms.ms_excode;
      pl_d.badvaddr = ms.ms_badvaddr;
      pl_d.bd       = ms.ms_bd;
      pl_d.eret     = ms.ms_inst_eret;
      pl_d.mfc0     = ms.ms_inst_mfc0;
      pl_d.mtc0     = ms.ms_inst_mtc0;
      pl_d.cp0_addr = ms.ms_cp0_addr;
    end

    ext_d = 6'd0;
    for (int i = 0; i < EXT_INT_W; i++) ext_d[i] = ext_int[i];

    // Free-running timer; an mtc0 to Count restarts the prescaler phase.
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    count_d = (presc_q == PRESC_MAX) ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ti_d       = ti_q | (count_q == compare_q);

    if (take_ex) begin
      exl_d     = 1'b1;
      exccode_d = ex_code;
      if (!exl_q) begin
        epc_d = pl_q.bd ? pl_q.pc - 32'd4 : pl_q.pc;
        bd_d  = pl_q.bd;
      end
      if (ex_code == 5'd4 || ex_code == 5'd5) badvaddr_d = pl_q.badvaddr;
    end else if (eret_fire) begin
      exl_d = 1'b0;
    end else if (mtc0_fire) begin
      case (pl_q.cp0_addr)
        A_COUNT: begin
          count_d = pl_q.result;
          presc_d = '0;
        end
        A_COMPARE: begin
          compare_d = pl_q.result;
          ti_d      = 1'b0;  // clear wins over a same-cycle match
        end
        A_STATUS: begin
          im_d  = pl_q.result[15:8];
          exl_d = pl_q.result[1];
          ie_d  = pl_q.result[0];
        end
        A_CAUSE: ip_sw_d = pl_q.result[9:8];
        A_EPC:   epc_d   = pl_q.result;
        default: ;
      endcase
    end

    flush_d    = take_ex | eret_fire;
    flush_pc_d = take_ex ? EX_ENTRY : (eret_fire ? epc_q : flush_pc_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      pl_q       <= '0;
      ext_q      <= 6'd0;
      count_q    <= 32'd0;
      presc_q    <= '0;
      compare_q  <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      flush_q    <= 1'b0;
      flush_pc_q <= 32'd0;
    end else begin
      ws_valid_q <= ws_valid_d;
      pl_q       <= pl_d;
      ext_q      <= ext_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      compare_q  <= compare_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign ms.ws_allowin      = 1'b1;
  assign rf_we              = {4{ws_valid_q & ~take_ex}} & pl_q.strb;
  assign rf_waddr           = pl_q.dest;
  assign rf_wdata           = pl_q.mfc0 ? cp0_rdata : pl_q.result;
  assign ws_dest_o          = ws_valid_q ? pl_q.dest : 5'd0;
  assign ws_inst_mfc0_o     = ws_valid_q & pl_q.mfc0;
  assign ws_flush           = flush_q;
  assign ws_flush_pc        = flush_pc_q;
  assign debug_wb_pc        = pl_q.pc;
  assign debug_wb_rf_wen    = rf_we;
  assign debug_wb_rf_wnum   = pl_q.dest;
  assign debug_wb_rf_wdata  = rf_wdata;

endmodule

// File: doc/wb_cp0_stage.md
Name: wb_cp0_stage

Overview:
- Parametrised successor of the current writeback stage for the MIPS pipeline: accepts retiring instructions from MEM via valid/allowin, drives GPR write-back and trace debug ports, and owns an embedded CP0.
- Generalises exception handling to any ExcCode with BadVAddr, adds a Count/Compare timer and hardware/software interrupts, and issues a single registered pipeline flush with its target PC.

Parameters:
- EXT_INT_W, 6, number of external interrupt lines mapped to Cause.IP[15:10] (1..6)
- COUNT_DIV, 2, clk cycles per Count increment (power of two, >=1)
- EX_ENTRY, 32'hBFC00380, exception vector driven as flush target

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ms_to_ws_valid  in  1  MEM holds a valid instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  32  instruction PC
- ms_result  in  32  ALU/load result; also mtc0 write data
- ms_dest  in  5  GPR destination
- ms_gr_strb  in  4  GPR byte write strobes
- ms_ex  in  1  upstream-detected exception
- ms_excode  in  5  ExcCode when ms_ex
- ms_badvaddr  in  32  faulting address (AdEL/AdES only)
- ms_bd  in  1  instruction is in a delay slot
- ms_inst_eret / ms_inst_mfc0 / ms_inst_mtc0  in  1 each  instruction class
- ms_cp0_addr  in  8  {rd,sel}
- ext_int  in  EXT_INT_W  level interrupt inputs
- rf_we  out  4  GPR byte enables
- rf_waddr  out  5  GPR address
- rf_wdata  out  32  GPR data
- ws_dest_o  out  5  dest for hazard logic, 0 when invalid
- ws_inst_mfc0_o  out  1  valid mfc0 in WB
- ws_flush  out  1  registered flush pulse
- ws_flush_pc  out  32  flush target, valid with ws_flush
- debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  trace

Behaviour:
- Handshake: ws_ready_go=1; ws_allowin=1 always. On reset ws_valid=0; else ws_valid<=ms_to_ws_valid. Payload latched when ms_to_ws_valid.
- Interrupt sampling: int_req = Status.IE & !Status.EXL & |(Cause.IP & Status.IM). Taken only on a valid WB instruction with no ms_ex; then excode=0 (Int). Precedence: upstream ex > int > eret > mtc0.
- take_ex = ws_valid & (ex | int_req). On take_ex: Status.EXL<=1; Cause.ExcCode<=code; if EXL was 0: EPC<=bd?pc-4:pc, Cause.BD<=bd; if code is 4 or 5, BadVAddr<=badvaddr. GPR write, mtc0 suppressed (rf_we=0).
- eret (valid, no take_ex): EXL<=0.
- ws_flush<=take_ex|eret, 1-cycle registered pulse, 0 at reset; ws_flush_pc<= EX_ENTRY for exception, current EPC for eret.
- CP0 map (addr = rd<<3|sel): BadVAddr 8/0 RO; Count 9/0 RW; Compare 11/0 RW; Status 12/0: BEV bit22 fixed 1, IM[15:8] RW, EXL[1], IE[0] RW, others 0; Cause 13/0: BD[31], TI[30], IP[15:10] hw, IP[9:8] RW, ExcCode[6:2], others 0; EPC 14/0 RW. Unmapped reads return 0; writes ignored.
- Reset values: Status=32'h0040_0000, Cause=0, Count=0, Compare=0, EPC=0, BadVAddr=0; all outputs 0.
- Cause.IP[10+i]=ext_int[i] sampled each cycle; IP[15] = ext_int[5] | TI when EXT_INT_W=6, else IP[15]=TI.
- Count: prescaler increments Count every COUNT_DIV cycles; wraps 32'hFFFFFFFF->0. mtc0 Count overrides increment and resets prescaler. TI<=1 when Count==Compare (Compare!=0 not required); mtc0 Compare clears TI, same-cycle match loses to clear.
- mfc0: rf_wdata = CP0 read (pre-write value); otherwise ms_result. rf_we={4{ws_valid & !take_ex}} & gr_strb.
- Reset mid-operation: all state, flush pulse, prescaler cleared immediately.

Test Plan:
- syscall (excode 8) at pc 0xBFC00100, bd=0 -> EPC=0xBFC00100, ExcCode=8, EXL=1, next cycle ws_flush=1, ws_flush_pc=0xBFC00380, rf_we=0.
- AdEL in delay slot pc 0xBFC00204, badvaddr 0x00000003 -> EPC=0xBFC00200, BD=1, BadVAddr=0x3; second exception with EXL=1 leaves EPC unchanged.
- mtc0 Compare=20, Count=0, Status=0x0040_8001 -> after 40 cycles (COUNT_DIV=2) TI=1, next valid instr takes Int (excode 0); mtc0 Compare clears TI.
- ext_int[1]=1 with IM[11]=1, IE=1 -> Int taken; with EXL=1 -> no exception, normal writeback.
- eret with EPC=0x8000_0010 -> EXL=0, flush pulse with ws_flush_pc=0x8000_0010.
- mfc0 Status after reset -> rf_wdata=0x0040_0000; reset asserted mid-flush -> ws_flush=0 immediately.
